// File: rtl/guess_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : guess_game_ctrl
// Purpose  : Guessing-game controller with an integrated datapath. A target
//            counter free-runs while waiting for the first press, the
//            registered guess is compared against it, the result is shown
//            on three LEDs and an attempt budget decides WON / LOST.
// Ports    : clk, reset_n      - clock, asynchronous active-low reset
//            i_enter           - debounced ENTER level (1 = pressed)
//            i_guess           - player guess, unsigned
//            o_over/o_under/o_equal - result LEDs of the last guess
//            o_attempts_left   - remaining guesses (0 in unlimited mode)
//            o_won / o_lost    - round outcome flags
//            o_actual          - current target, for the debug display
// Revision : 1.0 - initial release
// ============================================================================
module guess_game_ctrl #(
  parameter int WIDTH        = 7,
  parameter int MAX_VALUE    = 99,
  parameter int MAX_ATTEMPTS = 7,
  parameter int AW           = (MAX_ATTEMPTS == 0) ? 1 : $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enter,
  input  logic [WIDTH-1:0] i_guess,
  output logic             o_over,
  output logic             o_under,
  output logic             o_equal,
  output logic [AW-1:0]    o_attempts_left,
  output logic             o_won,
  output logic             o_lost,
  output logic [WIDTH-1:0] o_actual
);

  localparam logic [WIDTH-1:0] C_MAX_VALUE = WIDTH'(MAX_VALUE);
  localparam logic [AW-1:0]    C_ATTEMPTS  = AW'(MAX_ATTEMPTS);
  localparam logic [AW-1:0]    C_ONE       = AW'(1);
  localparam bit               C_LIMITED   = (MAX_ATTEMPTS != 0);

  typedef enum logic [2:0] {
    S_GEN   = 3'd0,
    S_PRESS = 3'd1,
    S_CMP   = 3'd2,
    S_SHOW  = 3'd3,
    S_WAIT  = 3'd4,
    S_WON   = 3'd5,
    S_LOST  = 3'd6,
    S_REL   = 3'd7
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] actual_q,   actual_d;
  logic [AW-1:0]    attempts_q, attempts_d;
  // Comparison result captured in S_CMP, published to the LEDs in S_SHOW.
  logic             over_f_q,   over_f_d;
  logic             under_f_q,  under_f_d;
  logic             equal_f_q,  equal_f_d;
  logic             led_over_q,  led_over_d;
  logic             led_under_q, led_under_d;
  logic             led_equal_q, led_equal_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_GEN;
      actual_q    <= '0;
      attempts_q  <= C_ATTEMPTS;
      over_f_q    <= 1'b0;
      under_f_q   <= 1'b0;
      equal_f_q   <= 1'b0;
      led_over_q  <= 1'b0;
      led_under_q <= 1'b0;
      led_equal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      actual_q    <= actual_d;
      attempts_q  <= attempts_d;
      over_f_q    <= over_f_d;
      under_f_q   <= under_f_d;
      equal_f_q   <= equal_f_d;
      led_over_q  <= led_over_d;
      led_under_q <= led_under_d;
      led_equal_q <= led_equal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    actual_d    = actual_q;
    attempts_d  = attempts_q;
    over_f_d    = over_f_q;
    under_f_d   = under_f_q;
    equal_f_d   = equal_f_q;
    led_over_d  = led_over_q;
    led_under_d = led_under_q;
    led_equal_d = led_equal_q;

    case (state_q)
      S_GEN: begin
        // The exit edge also counts, so the target depends on press timing.
        actual_d = (actual_q == C_MAX_VALUE) ? '0 : actual_q + 1'b1;
        if (i_enter) state_d = S_PRESS;
      end
      S_PRESS: begin
        if (!i_enter) state_d = S_CMP;
      end
      S_CMP: begin
        over_f_d  = (i_guess >  actual_q);
        under_f_d = (i_guess <  actual_q);
        equal_f_d = (i_guess == actual_q);
        state_d   = S_SHOW;
      end
      S_SHOW: begin
        led_over_d  = over_f_q;
        led_under_d = under_f_q;
        led_equal_d = equal_f_q;
        if (equal_f_q) begin
          state_d = S_WON;
        end else begin
          state_d = S_WAIT;
          if (C_LIMITED) begin
            // Zero guard keeps the counter from wrapping even if corrupted.
            if (attempts_q != '0) attempts_d = attempts_q - C_ONE;
            if (attempts_q <= C_ONE) state_d = S_LOST;
          end
        end
      end
      S_WAIT: begin
        if (i_enter) state_d = S_PRESS;
      end
      S_WON, S_LOST: begin
        if (i_enter) state_d = S_REL;
      end
      S_REL: begin
        if (!i_enter) begin
          state_d     = S_GEN;
          attempts_d  = C_ATTEMPTS;
          led_over_d  = 1'b0;
          led_under_d = 1'b0;
          led_equal_d = 1'b0;
        end
      end
      default: state_d = S_GEN;
    endcase
  end

  assign o_over          = led_over_q;
  assign o_under         = led_under_q;
  assign o_equal         = led_equal_q;
  assign o_attempts_left = attempts_q;
  assign o_won           = (state_q == S_WON);
  assign o_lost          = (state_q == S_LOST);
  assign o_actual        = actual_q;

endmodule
`default_nettype wire

// File: tb/tb_guess_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_guess_game_ctrl
// Purpose  : Self-checking bench for guess_game_ctrl. Three instances share
//            one stimulus stream: default build, a 2-attempt build and a
//            small-range unlimited build. A round-level model predicts every
//            output each cycle; directed literal checks pin known scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_enter;
  logic [6:0] i_guess;

  logic       ov [3];
  logic       un [3];
  logic       eq [3];
  logic       wn [3];
  logic       ls [3];
  logic [6:0] act [3];
  logic [2:0] att0;
  logic [1:0] att1;
  logic       att2;
  int         att_dut [3];

  assign att_dut[0] = {29'd0, att0};
  assign att_dut[1] = {30'd0, att1};
  assign att_dut[2] = {31'd0, att2};

  always #5 clk = ~clk;

  guess_game_ctrl #(.WIDTH(7), .MAX_VALUE(99), .MAX_ATTEMPTS(7)) u0 (
    .clk(clk), .reset_n(reset_n), .i_enter(i_enter), .i_guess(i_guess),
    .o_over(ov[0]), .o_under(un[0]), .o_equal(eq[0]), .o_attempts_left(att0),
    .o_won(wn[0]), .o_lost(ls[0]), .o_actual(act[0]));

  guess_game_ctrl #(.WIDTH(7), .MAX_VALUE(99), .MAX_ATTEMPTS(2)) u1 (
    .clk(clk), .reset_n(reset_n), .i_enter(i_enter), .i_guess(i_guess),
    .o_over(ov[1]), .o_under(un[1]), .o_equal(eq[1]), .o_attempts_left(att1),
    .o_won(wn[1]), .o_lost(ls[1]), .o_actual(act[1]));

  guess_game_ctrl #(.WIDTH(7), .MAX_VALUE(3), .MAX_ATTEMPTS(0)) u2 (
    .clk(clk), .reset_n(reset_n), .i_enter(i_enter), .i_guess(i_guess),
    .o_over(ov[2]), .o_under(un[2]), .o_equal(eq[2]), .o_attempts_left(att2),
    .o_won(wn[2]), .o_lost(ls[2]), .o_actual(act[2]));

  function automatic int mv(input int i);
    return (i == 2) ? 3 : 99;
  endfunction

  function automatic int ma(input int i);
    return (i == 0) ? 7 : ((i == 1) ? 2 : 0);
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Round-level model: a round is "counting" until pressed, each guess is a
  // press, a release, then a guess sample one edge later and a result on the
  // edge after that. A finished game waits for press+release to restart.
  int         m_act [3];
  int         m_att [3];
  bit         m_ov [3], m_un [3], m_eq [3], m_won [3], m_lost [3];
  bit         counting [3], await_rel [3], restart [3];
  int         pipe [3];
  logic [6:0] g_held [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_att[i] = ma(i);
      m_ov[i] = 0; m_un[i] = 0; m_eq[i] = 0; m_won[i] = 0; m_lost[i] = 0;
      counting[i] = 1; await_rel[i] = 0; restart[i] = 0; pipe[i] = 0;
      g_held[i] = '0;
    end
  endtask

  task automatic model_step(input int i, input bit en, input logic [6:0] gs);
    if (pipe[i] == 2) begin
      g_held[i] = gs;
      pipe[i] = 1;
    end else if (pipe[i] == 1) begin
      pipe[i] = 0;
      m_ov[i] = int'(g_held[i]) > m_act[i];
      m_un[i] = int'(g_held[i]) < m_act[i];
      m_eq[i] = int'(g_held[i]) == m_act[i];
      if (m_eq[i]) m_won[i] = 1;
      else if (ma(i) != 0) begin
        m_att[i] = m_att[i] - 1;
        if (m_att[i] == 0) m_lost[i] = 1;
      end
    end else if (await_rel[i]) begin
      if (!en) begin
        await_rel[i] = 0;
        if (restart[i]) begin
          restart[i] = 0;
          m_ov[i] = 0; m_un[i] = 0; m_eq[i] = 0;
          m_att[i] = ma(i);
          counting[i] = 1;
        end else begin
          pipe[i] = 2;
        end
      end
    end else if (counting[i]) begin
      m_act[i] = (m_act[i] + 1) % (mv(i) + 1);
      if (en) begin counting[i] = 0; await_rel[i] = 1; end
    end else if (en) begin
      await_rel[i] = 1;
      restart[i] = m_won[i] | m_lost[i];
      m_won[i] = 0; m_lost[i] = 0;
    end
  endtask

  always @(negedge reset_n) model_reset();

  // Single compare process: advance the model on the edge, check 1 ns later.
  always @(posedge clk) begin
    if (reset_n === 1'b1)
      for (int i = 0; i < 3; i++) model_step(i, i_enter, i_guess);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d_over", i),     int'(ov[i]),  int'(m_ov[i]));
      check($sformatf("d%0d_under", i),    int'(un[i]),  int'(m_un[i]));
      check($sformatf("d%0d_equal", i),    int'(eq[i]),  int'(m_eq[i]));
      check($sformatf("d%0d_won", i),      int'(wn[i]),  int'(m_won[i]));
      check($sformatf("d%0d_lost", i),     int'(ls[i]),  int'(m_lost[i]));
      check($sformatf("d%0d_actual", i),   int'(act[i]), m_act[i]);
      check($sformatf("d%0d_attempts", i), att_dut[i],   m_att[i]);
    end
  end

  task automatic press_release(input logic [6:0] g);
    i_guess = g;
    i_enter = 1'b1;
    @(negedge clk);
    i_enter = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_d%0d_leds", tag, i), int'({ov[i], un[i], eq[i]}), 0);
      check($sformatf("%s_d%0d_flags", tag, i), int'({wn[i], ls[i]}), 0);
      check($sformatf("%s_d%0d_actual", tag, i), int'(act[i]), 0);
      check($sformatf("%s_d%0d_attempts", tag, i), att_dut[i], ma(i));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    i_enter = 1'b0;
    i_guess = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Press sampled at edge 5: target 5 (99-range), 1 (3-range).
    press_release(7'd3);
    check("lit_d0_actual", int'(act[0]), 5);
    check("lit_d0_under", int'({ov[0], un[0], eq[0]}), 3'b010);
    check("lit_d0_att", att_dut[0], 6);
    check("lit_d1_att", att_dut[1], 1);
    check("lit_d2_actual", int'(act[2]), 1);
    check("lit_d2_over", int'(ov[2]), 1);

    press_release(7'd9);
    check("lit_d0_over", int'({ov[0], un[0], eq[0]}), 3'b100);
    check("lit_d0_att5", att_dut[0], 5);
    check("lit_d1_lost", int'(ls[1]), 1);
    check("lit_d1_att0", att_dut[1], 0);

    press_release(7'd5);
    check("lit_d0_equal", int'({ov[0], un[0], eq[0]}), 3'b001);
    check("lit_d0_won", int'(wn[0]), 1);
    check("lit_d0_att_hold", att_dut[0], 5);
    check("lit_d1_restart_leds", int'({ov[1], un[1], eq[1]}), 0);
    check("lit_d1_restart_att", att_dut[1], 2);
    check("lit_d1_resume_actual", int'(act[1]), 7);
    check("lit_d2_no_lost", int'(ls[2]), 0);

    press_release(7'd127);
    check("lit_d0_reload_att", att_dut[0], 7);
    check("lit_d1_over127", int'(ov[1]), 1);
    check("lit_d2_over127", int'(ov[2]), 1);
    check("lit_d2_att_zero", att_dut[2], 0);

    // Long hold must yield a single guess.
    i_guess = 7'd0;
    i_enter = 1'b1;
    repeat (50) @(negedge clk);
    i_enter = 1'b0;
    repeat (3) @(negedge clk);
    check("lit_d2_hold_lost", int'(ls[2]), 0);

    // Asynchronous reset while the comparison is in flight.
    i_guess = 7'd1;
    i_enter = 1'b1;
    @(negedge clk);
    i_enter = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    press_release(7'd0);
    check("lit_fresh_d0_att", att_dut[0], 6);
    check("lit_fresh_d0_under", int'(un[0]), 1);

    // Randomised play.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) i_enter = ~i_enter;
      if ($urandom_range(0, 9) == 0) i_guess = 7'($urandom_range(0, 127));
      else                           i_guess = 7'($urandom_range(0, 8));
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
